dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the core load/store path and an external port (program loader / debug / DMA).
- The core side sits between the ALU address/MemCtr write path and dmem. The external port lets a host preload or inspect data memory while the core runs.
- Stalls the core whenever it loses arbitration. Enforces fairness with round-robin ownership and a bounded hold count.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/rr_pick2.sv | 39 +++
 rtl/dmem_arbiter.sv | 100 ++++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and defaults for the data-memory path.
package riscv_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    typedef enum logic {
        SIDE_CORE = 1'b0,
        SIDE_EXT  = 1'b1
    } side_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin chooser with a bounded hold for the current owner.
module rr_pick2
    import riscv_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = $clog2(MAX_HOLD) + 1
) (
    input  logic [1:0]        req,
    input  owner_t            owner,
    input  logic [HOLD_W-1:0] hold_cnt,
    input  side_t             last_served,
    output owner_t            next_owner
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    // req[0] is the core, req[1] the external port
    always_comb begin
        next_owner = OWN_NONE;
        case (req)
            2'b00: next_owner = OWN_NONE;
            2'b01: next_owner = OWN_CORE;
            2'b10: next_owner = OWN_EXT;
            default: begin
                if (owner == OWN_CORE) begin
                    if (hold_cnt >= HOLD_LAST) next_owner = OWN_EXT;
                    else                       next_owner = OWN_CORE;
                end else if (owner == OWN_EXT) begin
                    if (hold_cnt >= HOLD_LAST) next_owner = OWN_CORE;
                    else                       next_owner = OWN_EXT;
                end else begin
                    if (last_served == SIDE_EXT) next_owner = OWN_CORE;
                    else                         next_owner = OWN_EXT;
                end
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path
// and an external host port; stalls the core while it is not granted.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_gnt,
    output logic              core_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned       HOLD_W    = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    owner_t            owner, owner_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    side_t             last_served, last_nxt;
    logic              ext_rd;

    assign core_gnt   = (owner == OWN_CORE) & core_req & ~rst;
    assign ext_gnt    = (owner == OWN_EXT) & ext_req & ~rst;
    assign core_stall = core_req & ~core_gnt;
    assign core_rdata = mem_rdata;
    assign ext_rd     = ext_gnt & ~ext_we;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_addr  = core_addr;
            mem_we    = core_we;
            mem_wdata = core_wdata;
        end else if (ext_gnt) begin
            mem_addr  = ext_addr;
            mem_we    = ext_we;
            mem_wdata = ext_wdata;
        end
    end

    rr_pick2 #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) u_pick (
        .req         ({ext_req, core_req}),
        .owner       (owner),
        .hold_cnt    (hold_cnt),
        .last_served (last_served),
        .next_owner  (owner_nxt)
    );

    // hold_cnt counts consecutive granted cycles of an unchanged owner
    always_comb begin
        hold_nxt = '0;
        last_nxt = last_served;
        if (core_gnt)     last_nxt = SIDE_CORE;
        else if (ext_gnt) last_nxt = SIDE_EXT;
        if ((owner_nxt == owner) && (core_gnt || ext_gnt)) begin
            if (hold_cnt >= HOLD_LAST) hold_nxt = hold_cnt;
            else                       hold_nxt = hold_cnt + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= OWN_NONE;
            hold_cnt    <= '0;
            last_served <= SIDE_EXT;
            ext_valid   <= 1'b0;
            ext_rdata   <= '0;
        end else begin
            owner       <= owner_nxt;
            hold_cnt    <= hold_nxt;
            last_served <= last_nxt;
            ext_valid   <= ext_rd;
            if (ext_rd) ext_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: one arbiter with MAX_HOLD=4 and one with MAX_HOLD=1, each on a small memory model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_core_req, a_core_we, a_core_gnt, a_core_stall;
    logic [31:0] a_core_addr, a_core_wdata, a_core_rdata;
    logic        a_ext_req, a_ext_we, a_ext_gnt, a_ext_valid;
    logic [31:0] a_ext_addr, a_ext_wdata, a_ext_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_we;

    logic        b_core_req, b_core_we, b_core_gnt, b_core_stall;
    logic [31:0] b_core_addr, b_core_wdata, b_core_rdata;
    logic        b_ext_req, b_ext_we, b_ext_gnt, b_ext_valid;
    logic [31:0] b_ext_addr, b_ext_wdata, b_ext_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_we;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];

    always @(posedge clk) if (a_mem_we) mem_a[a_mem_addr[7:2]] <= a_mem_wdata;
    always @(posedge clk) if (b_mem_we) mem_b[b_mem_addr[7:2]] <= b_mem_wdata;
    assign a_mem_rdata = mem_a[a_mem_addr[7:2]];
    assign b_mem_rdata = mem_b[b_mem_addr[7:2]];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .core_req(a_core_req), .core_we(a_core_we), .core_addr(a_core_addr),
        .core_wdata(a_core_wdata), .core_rdata(a_core_rdata), .core_gnt(a_core_gnt),
        .core_stall(a_core_stall),
        .ext_req(a_ext_req), .ext_we(a_ext_we), .ext_addr(a_ext_addr),
        .ext_wdata(a_ext_wdata), .ext_gnt(a_ext_gnt), .ext_rdata(a_ext_rdata),
        .ext_valid(a_ext_valid),
        .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .core_req(b_core_req), .core_we(b_core_we), .core_addr(b_core_addr),
        .core_wdata(b_core_wdata), .core_rdata(b_core_rdata), .core_gnt(b_core_gnt),
        .core_stall(b_core_stall),
        .ext_req(b_ext_req), .ext_we(b_ext_we), .ext_addr(b_ext_addr),
        .ext_wdata(b_ext_wdata), .ext_gnt(b_ext_gnt), .ext_rdata(b_ext_rdata),
        .ext_valid(b_ext_valid),
        .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[16] = 32'h0BAD_F00D;
        mem_b[1]  = 32'h1111_1111;
        mem_b[2]  = 32'h2222_2222;

        rst = 1'b1;
        a_core_req = 1'b1; a_core_we = 1'b1; a_core_addr = 32'h40; a_core_wdata = 32'hFFFF_0000;
        a_ext_req  = 1'b1; a_ext_we  = 1'b1; a_ext_addr  = 32'h44; a_ext_wdata  = 32'h5A5A_5A5A;
        b_core_req = 1'b0; b_core_we = 1'b0; b_core_addr = 32'h0;  b_core_wdata = 32'h0;
        b_ext_req  = 1'b0; b_ext_we  = 1'b0; b_ext_addr  = 32'h0;  b_ext_wdata  = 32'h0;

        // requests held during reset must not be granted
        mid();
        check_eq("rst_core_gnt", a_core_gnt, 0);
        check_eq("rst_ext_gnt", a_ext_gnt, 0);
        check_eq("rst_mem_we", a_mem_we, 0);
        check_eq("rst_mem_addr", a_mem_addr, 0);
        next_cycle();
        mid();
        check_eq("rst_ext_valid", a_ext_valid, 0);
        check_eq("rst_ext_rdata", a_ext_rdata, 0);

        // core write after reset: one stall cycle, then grant
        next_cycle();
        rst = 1'b0;
        a_ext_req = 1'b0;
        a_core_req = 1'b1; a_core_we = 1'b1; a_core_addr = 32'h10; a_core_wdata = 32'hDEAD_BEEF;
        mid();
        check_eq("c1_stall", a_core_stall, 1);
        check_eq("c1_gnt", a_core_gnt, 0);
        check_eq("c1_mem_we", a_mem_we, 0);
        next_cycle();
        mid();
        check_eq("c2_gnt", a_core_gnt, 1);
        check_eq("c2_stall", a_core_stall, 0);
        check_eq("c2_mem_we", a_mem_we, 1);
        check_eq("c2_mem_addr", a_mem_addr, 32'h10);
        check_eq("c2_mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
        next_cycle();
        a_core_addr = 32'h20; a_core_wdata = 32'h1234_5678;
        mid();
        check_eq("b2b_gnt", a_core_gnt, 1);
        check_eq("b2b_mem_addr", a_mem_addr, 32'h20);
        next_cycle();
        a_core_req = 1'b0; a_core_we = 1'b0;
        mid();
        check_eq("drop_core_gnt", a_core_gnt, 0);
        check_eq("dmem_0x10", mem_a[4], 32'hDEAD_BEEF);
        check_eq("dmem_0x20", mem_a[8], 32'h1234_5678);

        // external read of 0x20
        next_cycle();
        a_ext_req = 1'b1; a_ext_we = 1'b0; a_ext_addr = 32'h20;
        mid();
        check_eq("ext_arb_latency", a_ext_gnt, 0);
        next_cycle();
        mid();
        check_eq("ext_gnt", a_ext_gnt, 1);
        check_eq("ext_mem_we", a_mem_we, 0);
        check_eq("ext_mem_addr", a_mem_addr, 32'h20);
        check_eq("ext_valid_early", a_ext_valid, 0);
        next_cycle();
        a_ext_req = 1'b0;
        mid();
        check_eq("ext_valid_pulse", a_ext_valid, 1);
        check_eq("ext_rdata", a_ext_rdata, 32'h1234_5678);
        next_cycle();
        mid();
        check_eq("ext_valid_end", a_ext_valid, 0);
        check_eq("ext_rdata_hold", a_ext_rdata, 32'h1234_5678);

        // both requesting; last grant went to ext so the core wins the tie
        next_cycle();
        a_core_req = 1'b1; a_core_we = 1'b0; a_core_addr = 32'h10;
        a_ext_req  = 1'b1; a_ext_we  = 1'b0; a_ext_addr  = 32'h20;
        mid();
        check_eq("both0_stall", a_core_stall, 1);
        check_eq("both0_core_gnt", a_core_gnt, 0);
        check_eq("both0_ext_gnt", a_ext_gnt, 0);
        for (int i = 1; i <= 12; i++) begin
            logic exp_core;
            exp_core = (((i - 1) / 4) % 2) == 0;
            next_cycle();
            mid();
            check_eq($sformatf("rr_core_gnt[%0d]", i), a_core_gnt, exp_core);
            check_eq($sformatf("rr_ext_gnt[%0d]", i), a_ext_gnt, !exp_core);
            check_eq($sformatf("rr_stall[%0d]", i), a_core_stall, !exp_core);
            if (i == 1) check_eq("core_rdata", a_core_rdata, 32'hDEAD_BEEF);
        end
        for (int i = 13; i <= 14; i++) begin
            next_cycle();
            mid();
            check_eq($sformatf("rr_ext_gnt[%0d]", i), a_ext_gnt, 1);
        end

        // ext drops mid-hold: gnt falls at once, core owns next cycle with a fresh hold
        next_cycle();
        a_ext_req = 1'b0;
        mid();
        check_eq("drop_ext_gnt", a_ext_gnt, 0);
        check_eq("drop_core_stall", a_core_stall, 1);
        next_cycle();
        a_ext_req = 1'b1;
        mid();
        check_eq("handoff_core_gnt", a_core_gnt, 1);
        for (int i = 17; i <= 19; i++) begin
            next_cycle();
            mid();
            check_eq($sformatf("fresh_hold_core_gnt[%0d]", i), a_core_gnt, 1);
        end
        next_cycle();
        mid();
        check_eq("fresh_hold_ext_gnt", a_ext_gnt, 1);
        check_eq("fresh_hold_stall", a_core_stall, 1);
        next_cycle();
        a_core_req = 1'b0; a_ext_req = 1'b0;

        // reset lands on a granted core write
        next_cycle();
        a_core_req = 1'b1; a_core_we = 1'b1; a_core_addr = 32'h40; a_core_wdata = 32'hAAAA_5555;
        mid();
        check_eq("rstw_stall", a_core_stall, 1);
        next_cycle();
        rst = 1'b1;
        mid();
        check_eq("rstw_gnt", a_core_gnt, 0);
        check_eq("rstw_mem_we", a_mem_we, 0);
        check_eq("rstw_core_stall", a_core_stall, 1);
        next_cycle();
        rst = 1'b0;
        a_core_req = 1'b0;
        mid();
        check_eq("rstw_dmem_0x40", mem_a[16], 32'h0BAD_F00D);
        check_eq("rstw_after_gnt", a_core_gnt, 0);
        check_eq("rstw_after_mem_we", a_mem_we, 0);
        check_eq("rstw_after_ext_valid", a_ext_valid, 0);
        check_eq("rstw_after_ext_rdata", a_ext_rdata, 0);
        next_cycle();
        a_core_req = 1'b1;
        mid();
        check_eq("rereq_stall", a_core_stall, 1);
        next_cycle();
        mid();
        check_eq("rereq_gnt", a_core_gnt, 1);
        next_cycle();
        a_core_req = 1'b0;
        mid();
        check_eq("rereq_dmem_0x40", mem_a[16], 32'hAAAA_5555);

        // MAX_HOLD=1: strict alternation, no idle cycles
        next_cycle();
        b_core_req = 1'b1; b_core_we = 1'b0; b_core_addr = 32'h4;
        b_ext_req  = 1'b1; b_ext_we  = 1'b0; b_ext_addr  = 32'h8;
        mid();
        check_eq("alt0_core_gnt", b_core_gnt, 0);
        check_eq("alt0_ext_gnt", b_ext_gnt, 0);
        for (int i = 1; i <= 6; i++) begin
            logic exp_core;
            exp_core = (i % 2) == 1;
            next_cycle();
            mid();
            check_eq($sformatf("alt_core_gnt[%0d]", i), b_core_gnt, exp_core);
            check_eq($sformatf("alt_ext_gnt[%0d]", i), b_ext_gnt, !exp_core);
            check_eq($sformatf("alt_busy[%0d]", i), b_core_gnt | b_ext_gnt, 1);
            if (i == 1) check_eq("alt_core_rdata", b_core_rdata, 32'h1111_1111);
            if (i == 3) begin
                check_eq("alt_ext_valid", b_ext_valid, 1);
                check_eq("alt_ext_rdata", b_ext_rdata, 32'h2222_2222);
            end
        end
        next_cycle();
        b_core_req = 1'b0; b_ext_req = 1'b0;
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
